// File: rtl/reg_writeback_unit.sv
// Purpose: sole register-file write port driver; merges ALU and LSU/MDU results, tracks pending destinations.
// Latency: a write selected in cycle N shows on rf_wr_en_o/rf_des_o/rf_des_dat_o in N+1; LSU results are written at N+2 or later.
// Backpressure: the ALU is never stalled; LSU stalls only through lsu_ready_o (= !full, registered-count based). Optional macro: WB_BYPASS_EN.

// Purpose: generic circular-buffer FIFO with valid/ready on both sides.
// Latency: an entry pushed at an edge is visible at the head from the next cycle; there is no same-cycle bypass.
// Backpressure: in_rdy is derived from the stored count only, so a same-cycle pop never raises it combinationally.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;

    assign full    = (cnt == DEPTH_CNT);
    assign in_rdy  = !full;
    assign out_vld = (cnt != '0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign out_dat = mem[rd_ptr];

    // Storage needs no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// Purpose: arbitrates ALU and buffered LSU results onto the register-file write port and keeps the busy scoreboard.
// Latency: one registered stage on the write port; operand forwarding (WB_BYPASS_EN) is combinational.
// Backpressure: ALU has absolute priority and may starve the FIFO; upstream LSU sees only lsu_ready_o.
module reg_writeback_unit #(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_dat_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_dat_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    output logic [31:0] busy_o,
    output logic        fifo_full_o,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_des_o,
    output logic [31:0] rf_des_dat_o,
    input  logic [4:0]  rd_src_1_i,
    input  logic [4:0]  rd_src_2_i,
    input  logic [31:0] rf_src_1_dat_i,
    input  logic [31:0] rf_src_2_dat_i,
    output logic [31:0] src_1_dat_o,
    output logic [31:0] src_2_dat_o
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_ent_t;

    wb_ent_t     lsu_ent;
    wb_ent_t     head;
    logic        head_vld;
    logic        pop;
    logic        fifo_full;
    logic        sel_vld;
    logic [4:0]  sel_rd;
    logic [31:0] sel_dat;
    logic [31:0] busy;
    logic [31:0] busy_nxt;

    assign lsu_ent.rd  = lsu_rd_i;
    assign lsu_ent.dat = lsu_dat_i;

    // The head is consumed whenever the ALU leaves the write port free.
    assign pop = head_vld && !alu_valid_i;

    wb_fifo #(
        .WIDTH ($bits(wb_ent_t)),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (lsu_valid_i),
        .in_rdy  (lsu_ready_o),
        .in_dat  (lsu_ent),
        .out_vld (head_vld),
        .out_rdy (!alu_valid_i),
        .out_dat (head),
        .full    (fifo_full)
    );

    assign fifo_full_o = fifo_full;

    // Select this cycle's write: ALU first, otherwise the FIFO head, otherwise nothing.
    always_comb begin
        sel_vld = 1'b0;
        sel_rd  = '0;
        sel_dat = '0;
        if (alu_valid_i) begin
            sel_vld = 1'b1;
            sel_rd  = alu_rd_i;
            sel_dat = alu_dat_i;
        end else if (head_vld) begin
            sel_vld = 1'b1;
            sel_rd  = head.rd;
            sel_dat = head.dat;
        end
    end

    // Register the write port; x0 writes are consumed but never enabled, and idle cycles hold index/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en_o   <= 1'b0;
            rf_des_o     <= '0;
            rf_des_dat_o <= '0;
        end else begin
            rf_wr_en_o <= sel_vld && (sel_rd != 5'd0);
            if (sel_vld && (sel_rd != 5'd0)) begin
                rf_des_o     <= sel_rd;
                rf_des_dat_o <= sel_dat;
            end
        end
    end

    // Scoreboard update: clear on FIFO pop, then set on issue so a same-rd set wins; bit 0 is never busy.
    always_comb begin
        busy_nxt = busy;
        if (pop && (head.rd != 5'd0)) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != 5'd0)) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_o = busy;

`ifdef WB_BYPASS_EN
    // Forward the write being committed this cycle to decode.
    always_comb begin
        src_1_dat_o = rf_src_1_dat_i;
        src_2_dat_o = rf_src_2_dat_i;
        if (rf_wr_en_o && (rf_des_o == rd_src_1_i) && (rd_src_1_i != 5'd0)) begin
            src_1_dat_o = rf_des_dat_o;
        end
        if (rf_wr_en_o && (rf_des_o == rd_src_2_i) && (rd_src_2_i != 5'd0)) begin
            src_2_dat_o = rf_des_dat_o;
        end
    end
`else
    // No forwarding: decode stalls an extra cycle on read-after-write, so read indices are not needed.
    logic unused_src;
    assign unused_src  = ^{rd_src_1_i, rd_src_2_i};
    assign src_1_dat_o = rf_src_1_dat_i;
    assign src_2_dat_o = rf_src_2_dat_i;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Purpose: self-checking bench for reg_writeback_unit against a queue-based reference model.
// Latency: model predicts registered outputs one edge after inputs are applied.
// Backpressure: model accepts an LSU result only when its queue holds fewer than DEPTH entries.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i, lsu_valid_i, issue_valid_i;
    logic [4:0]  alu_rd_i, lsu_rd_i, issue_rd_i, rd_src_1_i, rd_src_2_i;
    logic [31:0] alu_dat_i, lsu_dat_i, rf_src_1_dat_i, rf_src_2_dat_i;
    logic        lsu_ready_o, fifo_full_o, rf_wr_en_o;
    logic [4:0]  rf_des_o;
    logic [31:0] rf_des_dat_o, busy_o, src_1_dat_o, src_2_dat_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: pending LSU results in arrival order, busy set, last committed write.
    logic [36:0] q[$];
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_des;
    logic [31:0] m_dat;

    reg_writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_dat_i(alu_dat_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_dat_i(lsu_dat_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .busy_o(busy_o), .fifo_full_o(fifo_full_o),
        .rf_wr_en_o(rf_wr_en_o), .rf_des_o(rf_des_o), .rf_des_dat_o(rf_des_dat_o),
        .rd_src_1_i(rd_src_1_i), .rd_src_2_i(rd_src_2_i),
        .rf_src_1_dat_i(rf_src_1_dat_i), .rf_src_2_dat_i(rf_src_2_dat_i),
        .src_1_dat_o(src_1_dat_o), .src_2_dat_o(src_2_dat_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = 0; alu_dat_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_dat_i = 0;
        issue_valid_i = 0; issue_rd_i = 0;
        rd_src_1_i = 0; rd_src_2_i = 0; rf_src_1_dat_i = 0; rf_src_2_dat_i = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_wen = 0; m_des = 0; m_dat = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then sample #1 after the edge.
    task automatic tick();
        bit          can_push;
        logic [36:0] e;
        can_push = (q.size() < DEPTH);
        if (alu_valid_i) begin
            m_wen = (alu_rd_i != 0);
            if (alu_rd_i != 0) begin m_des = alu_rd_i; m_dat = alu_dat_i; end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_wen = (e[36:32] != 0);
            if (e[36:32] != 0) begin
                m_des = e[36:32]; m_dat = e[31:0];
                m_busy[e[36:32]] = 1'b0;
            end
        end else begin
            m_wen = 0;
        end
        if (lsu_valid_i && can_push) q.push_back({lsu_rd_i, lsu_dat_i});
        if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_src(input logic [4:0] rs, input logic [31:0] raw);
`ifdef WB_BYPASS_EN
        if (m_wen && m_des == rs && rs != 0) return m_dat;
`endif
        return raw;
    endfunction

    task automatic test_reset_init();
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL init_wr_en: got %0h want 0", rf_wr_en_o); end
        n_cmp++; if (rf_des_o !== 5'd0) begin n_fail++; $display("FAIL init_des: got %0h want 0", rf_des_o); end
        n_cmp++; if (rf_des_dat_o !== 32'd0) begin n_fail++; $display("FAIL init_dat: got %0h want 0", rf_des_dat_o); end
        n_cmp++; if (busy_o !== 32'd0) begin n_fail++; $display("FAIL init_busy: got %0h want 0", busy_o); end
        n_cmp++; if (fifo_full_o !== 1'b0) begin n_fail++; $display("FAIL init_full: got %0h want 0", fifo_full_o); end
        rst_n = 1;
        @(posedge clk); #1;
        n_cmp++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL init_ready: got %0h want 1", lsu_ready_o); end
    endtask

    task automatic test_alu_latency();
        idle_inputs();
        alu_valid_i = 1; alu_rd_i = 5; alu_dat_i = 32'hDEADBEEF;
        tick();
        n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL alu_latency: got %0h/%0d/%0h want 1/5/deadbeef", rf_wr_en_o, rf_des_o, rf_des_dat_o); end
        alu_valid_i = 0;
        tick();
        n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b0, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL alu_idle_hold: got %0h/%0d/%0h want 0/5/deadbeef", rf_wr_en_o, rf_des_o, rf_des_dat_o); end
    endtask

    task automatic test_lsu_no_bypass();
        idle_inputs();
        lsu_valid_i = 1; lsu_rd_i = 6; lsu_dat_i = 32'h66;
        tick();
        n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL lsu_n1: got %0h want 0", rf_wr_en_o); end
        lsu_valid_i = 0;
        tick();
        n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b1, 5'd6, 32'h66})
            begin n_fail++; $display("FAIL lsu_n2: got %0h/%0d/%0h want 1/6/66", rf_wr_en_o, rf_des_o, rf_des_dat_o); end
        tick();
        n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL lsu_n3: got %0h want 0", rf_wr_en_o); end
    endtask

    task automatic test_alu_priority();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            alu_valid_i = 1; alu_rd_i = 5'(i + 1); alu_dat_i = $urandom;
            lsu_valid_i = 1; lsu_rd_i = 7; lsu_dat_i = 32'h11 + i;
            tick();
            n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b1, 5'(i + 1), alu_dat_i})
                begin n_fail++; $display("FAIL prio_alu%0d: got %0h/%0d/%0h want 1/%0d/%0h", i, rf_wr_en_o, rf_des_o, rf_des_dat_o, i + 1, alu_dat_i); end
            n_cmp++; if ({lsu_ready_o, fifo_full_o} !== ((i < 3) ? 2'b10 : 2'b01))
                begin n_fail++; $display("FAIL prio_ready%0d: got rdy=%0h full=%0h want rdy=%0d", i, lsu_ready_o, fifo_full_o, i < 3); end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b1, 5'd7, 32'h11 + k})
                begin n_fail++; $display("FAIL prio_drain%0d: got %0h/%0d/%0h want 1/7/%0h", k, rf_wr_en_o, rf_des_o, rf_des_dat_o, 32'h11 + k); end
        end
        tick();
        n_cmp++; if ({rf_wr_en_o, lsu_ready_o} !== 2'b01) begin n_fail++; $display("FAIL prio_empty: got wen=%0h rdy=%0h want 0/1", rf_wr_en_o, lsu_ready_o); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        issue_valid_i = 1; issue_rd_i = 9;
        tick();
        issue_valid_i = 0;
        n_cmp++; if (busy_o !== 32'h200) begin n_fail++; $display("FAIL sb_set: got %0h want 200", busy_o); end
        tick(); tick();
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_dat_i = 32'h99;
        tick();
        lsu_valid_i = 0;
        n_cmp++; if (busy_o[9] !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got %0h want 1", busy_o[9]); end
        tick();
        n_cmp++; if ({busy_o[9], rf_wr_en_o, rf_des_o} !== {1'b0, 1'b1, 5'd9})
            begin n_fail++; $display("FAIL sb_clear: got busy=%0h wen=%0h des=%0d want 0/1/9", busy_o[9], rf_wr_en_o, rf_des_o); end
        issue_valid_i = 1; issue_rd_i = 9;
        tick();
        issue_valid_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_dat_i = 32'h9A;
        tick();
        lsu_valid_i = 0;
        issue_valid_i = 1; issue_rd_i = 9;
        tick();
        issue_valid_i = 0;
        n_cmp++; if ({busy_o[9], rf_wr_en_o} !== 2'b11) begin n_fail++; $display("FAIL sb_set_wins: got busy=%0h wen=%0h want 1/1", busy_o[9], rf_wr_en_o); end
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_dat_i = 32'h9B;
        tick();
        lsu_valid_i = 0;
        tick();
        n_cmp++; if (busy_o !== m_busy) begin n_fail++; $display("FAIL sb_final: got %0h want %0h", busy_o, m_busy); end
    endtask

    task automatic test_x0();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            alu_valid_i = 1; alu_rd_i = 0; alu_dat_i = $urandom;
            lsu_valid_i = 1; lsu_rd_i = 0; lsu_dat_i = $urandom;
            issue_valid_i = 1; issue_rd_i = 0;
            tick();
            n_cmp++; if ({rf_wr_en_o, busy_o[0]} !== 2'b00) begin n_fail++; $display("FAIL x0_alu%0d: got wen=%0h busy0=%0h want 0/0", i, rf_wr_en_o, busy_o[0]); end
        end
        n_cmp++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL x0_full: got %0h want 0", lsu_ready_o); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (rf_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL x0_drain%0d: got %0h want 0", i, rf_wr_en_o); end
        end
        n_cmp++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0h want 1", lsu_ready_o); end
        lsu_valid_i = 1; lsu_rd_i = 5; lsu_dat_i = 32'h5A5A;
        tick();
        lsu_valid_i = 0;
        tick();
        n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o} !== {1'b1, 5'd5, 32'h5A5A})
            begin n_fail++; $display("FAIL x0_empty: got %0h/%0d/%0h want 1/5/5a5a", rf_wr_en_o, rf_des_o, rf_des_dat_o); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef WB_BYPASS_EN
        want = 32'h55;
`else
        want = 32'hAA;
`endif
        idle_inputs();
        alu_valid_i = 1; alu_rd_i = 3; alu_dat_i = 32'h55;
        tick();
        alu_valid_i = 0;
        rd_src_1_i = 3; rf_src_1_dat_i = 32'hAA;
        rd_src_2_i = 4; rf_src_2_dat_i = 32'hBB;
        #1;
        n_cmp++; if (src_1_dat_o !== want) begin n_fail++; $display("FAIL byp_src1: got %0h want %0h", src_1_dat_o, want); end
        n_cmp++; if (src_2_dat_o !== 32'hBB) begin n_fail++; $display("FAIL byp_src2_miss: got %0h want bb", src_2_dat_o); end
        tick();
        n_cmp++; if (src_1_dat_o !== 32'hAA) begin n_fail++; $display("FAIL byp_after: got %0h want aa", src_1_dat_o); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            alu_valid_i = 1; alu_rd_i = 1; alu_dat_i = $urandom;
            lsu_valid_i = 1; lsu_rd_i = 4; lsu_dat_i = 32'h40 + i;
            issue_valid_i = (i == 0); issue_rd_i = 8;
            tick();
        end
        idle_inputs();
        n_cmp++; if (busy_o !== 32'h100) begin n_fail++; $display("FAIL rst_pre_busy: got %0h want 100", busy_o); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if ({rf_wr_en_o, rf_des_o, rf_des_dat_o, busy_o, fifo_full_o} !== 71'd0)
            begin n_fail++; $display("FAIL rst_async: got wen=%0h des=%0h dat=%0h busy=%0h full=%0h want all 0", rf_wr_en_o, rf_des_o, rf_des_dat_o, busy_o, fifo_full_o); end
        #1 rst_n = 1;
        model_reset();
        n_cmp++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0h want 1", lsu_ready_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({rf_wr_en_o, busy_o, lsu_ready_o} !== {1'b0, 32'd0, 1'b1})
                begin n_fail++; $display("FAIL rst_post%0d: got wen=%0h busy=%0h rdy=%0h want 0/0/1", i, rf_wr_en_o, busy_o, lsu_ready_o); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_valid_i   = ($urandom_range(0, 99) < 40);
            alu_rd_i      = 5'($urandom_range(0, 31));
            alu_dat_i     = $urandom;
            lsu_valid_i   = ($urandom_range(0, 99) < 60);
            lsu_rd_i      = 5'($urandom_range(0, 31));
            lsu_dat_i     = $urandom;
            issue_valid_i = ($urandom_range(0, 99) < 30);
            issue_rd_i    = 5'($urandom_range(0, 31));
            rd_src_1_i    = ($urandom_range(0, 2) == 0) ? m_des : 5'($urandom_range(0, 31));
            rd_src_2_i    = 5'($urandom_range(0, 31));
            rf_src_1_dat_i = $urandom;
            rf_src_2_dat_i = $urandom;
            #1;
            n_cmp++; if (src_1_dat_o !== exp_src(rd_src_1_i, rf_src_1_dat_i))
                begin n_fail++; $display("FAIL rnd_src1 c%0d: got %0h want %0h", c, src_1_dat_o, exp_src(rd_src_1_i, rf_src_1_dat_i)); end
            n_cmp++; if (src_2_dat_o !== exp_src(rd_src_2_i, rf_src_2_dat_i))
                begin n_fail++; $display("FAIL rnd_src2 c%0d: got %0h want %0h", c, src_2_dat_o, exp_src(rd_src_2_i, rf_src_2_dat_i)); end
            tick();
            n_cmp++; if (rf_wr_en_o !== m_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %0h want %0h", c, rf_wr_en_o, m_wen); end
            if (m_wen) begin
                n_cmp++; if ({rf_des_o, rf_des_dat_o} !== {m_des, m_dat})
                    begin n_fail++; $display("FAIL rnd_write c%0d: got %0d/%0h want %0d/%0h", c, rf_des_o, rf_des_dat_o, m_des, m_dat); end
            end
            n_cmp++; if (busy_o !== m_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %0h want %0h", c, busy_o, m_busy); end
            n_cmp++; if ({lsu_ready_o, fifo_full_o} !== {q.size() < DEPTH, q.size() == DEPTH})
                begin n_fail++; $display("FAIL rnd_flow c%0d: got rdy=%0h full=%0h want qsize=%0d", c, lsu_ready_o, fifo_full_o, q.size()); end
        end
    endtask

    initial begin
        test_reset_init();
        test_alu_latency();
        test_lsu_no_bypass();
        test_alu_priority();
        test_scoreboard();
        test_x0();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Sole driver of the core register file's single write port (write enable, destination index, write data).
- Merges two result sources:
  - single-cycle ALU results, which cannot be back-pressured;
  - multi-cycle LSU/MDU results, which use a valid/ready handshake and are buffered in a small FIFO.
- Keeps a pending-destination scoreboard that decode uses for stall decisions.
- Sits between the execute/memory stages and the register file.

Parameters:
- FIFO_DEPTH, 4, LSU result buffer entries; power of two, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU result valid this cycle
- alu_rd_i  in  5  ALU destination index
- alu_dat_i  in  32  ALU result
- lsu_valid_i  in  1  LSU result valid
- lsu_ready_o  out  1  FIFO can accept (= !full)
- lsu_rd_i  in  5  LSU destination index
- lsu_dat_i  in  32  LSU result
- issue_valid_i  in  1  long-latency op issued this cycle
- issue_rd_i  in  5  its destination index
- busy_o  out  32  pending-destination scoreboard
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries
- rf_wr_en_o  out  1  register file write enable
- rf_des_o  out  5  register file destination index
- rf_des_dat_o  out  32  register file write data
- rd_src_1_i, rd_src_2_i  in  5  decode read indices
- rf_src_1_dat_i, rf_src_2_dat_i  in  32  raw register file read data
- src_1_dat_o, src_2_dat_o  out  32  operand data to decode

Behaviour:
- Reset: the asynchronous reset clears all state, including mid-transfer:
  - FIFO emptied, pointers and count = 0;
  - busy_o = 0;
  - rf_wr_en_o = 0, rf_des_o = 0, rf_des_dat_o = 0;
  - fifo_full_o = 0; lsu_ready_o = 1 once reset releases.
- Write port: rf_wr_en_o, rf_des_o and rf_des_dat_o are registered. A selection made in cycle N appears in cycle N+1, and the register file commits it at the end of N+1.
- Arbitration (each cycle):
  - ALU has absolute priority. If alu_valid_i=1, the ALU write is selected.
  - Otherwise, if the FIFO is non-empty, the head entry is selected and popped.
  - If neither, rf_wr_en_o=0 next cycle; rf_des_o and rf_des_dat_o hold their values.
- x0 writes:
  - Any selected write with rd=0 drives rf_wr_en_o=0 next cycle.
  - It is still consumed: the FIFO entry is popped, the ALU result is dropped.
- LSU handshake:
  - Transfer when lsu_valid_i && lsu_ready_o; the entry is pushed at that edge.
  - There is no same-cycle bypass: the earliest write is selected in N+1, with rf_wr_en_o high in N+2.
  - Push and pop in the same cycle are allowed when non-empty; count is unchanged.
  - When full, lsu_ready_o=0. A pop in the same cycle does not raise ready combinationally; ready rises the next cycle.
- FIFO: circular buffer; pointers wrap modulo FIFO_DEPTH; count width PTR_W+1.
- Scoreboard:
  - issue_valid_i with issue_rd_i≠0 sets busy[rd] at the edge.
  - A FIFO pop with rd≠0 clears busy[rd] at the same edge the write is selected.
  - Set and clear of the same rd in the same cycle: set wins.
  - ALU writes never touch busy.
  - busy_o[0] is constant 0.
- Ordering: WAW ordering between ALU and LSU results to the same rd is the issuer's responsibility; this unit does not reorder.
- Sustained ALU traffic may starve the FIFO indefinitely. Back-pressure reaches upstream only through lsu_ready_o.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: src_k_dat_o = rf_des_dat_o when rf_wr_en_o=1, rf_des_o=rd_src_k_i and rd_src_k_i≠0; otherwise rf_src_k_dat_i. This forwards the write being committed this cycle.
- Undefined: src_k_dat_o = rf_src_k_dat_i unconditionally. Decode must stall one extra cycle for read-after-write.

Test Plan:
- Reset behaviour: assert rst_n=0 while the FIFO holds 3 entries and busy_o=0x0000_0100, then release -> all outputs 0, lsu_ready_o=1, no write issued.
- ALU write latency: alu_valid_i=1, rd=5, dat=0xDEADBEEF in cycle 0 -> cycle 1 shows rf_wr_en_o=1, rf_des_o=5, rf_des_dat_o=0xDEADBEEF; cycle 2 shows rf_wr_en_o=0.
- ALU priority and FIFO fill: LSU pushes rd=7, 0x11 while the ALU is valid every cycle for 6 cycles -> no LSU write during those cycles; the FIFO fills at 4 entries with lsu_ready_o=0; after the ALU stops, the 4 LSU writes appear on consecutive cycles in push order.
- Scoreboard: issue rd=9 in cycle 0 -> busy_o[9]=1 from cycle 1; LSU result rd=9 pushed cycle 3 -> popped cycle 4, busy_o[9]=0 in cycle 5; issue rd=9 in the same cycle as the pop -> busy_o[9] stays 1.
- x0 handling: ALU rd=0 and LSU rd=0 writes -> rf_wr_en_o never asserted, FIFO count returns to 0, busy_o[0]=0 even after issue rd=0.
- Bypass (WB_BYPASS_EN defined): rf_wr_en_o=1, rf_des_o=3, dat=0x55 while rd_src_1_i=3, rf_src_1_dat_i=0xAA -> src_1_dat_o=0x55; the same stimulus without the macro -> 0xAA.
